program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Writer side of the instruction ROM/RAM that MiniAlu fetches from. Receives a framed byte stream
//  (valid/ready), assembles 28-bit instruction words and writes them to sequential instruction-memory
//  addresses starting at 0. Holds the CPU in reset until a checksum-verified load completes.
// PARAMETERS
//  ADDR_WIDTH   16   instruction-memory address width (matches IP width)
//  INSTR_WIDTH  28   instruction word width; each word arrives as 4 bytes, MSB first, bits above INSTR_WIDTH dropped
// PORTS
//  Clock          in   1            system clock, all logic on rising edge
//  Reset          in   1            synchronous, active-low reset
//  iByte          in   8            incoming stream byte
//  iByteValid     in   1            iByte valid this cycle
//  oByteReady     out  1            loader accepts iByte this cycle
//  oWriteEnable   out  1            one-cycle instruction-memory write strobe
//  oWriteAddress  out  ADDR_WIDTH   write address
//  oInstruction   out  INSTR_WIDTH  write data
//  oCpuReset      out  1            active-high reset to the CPU core; 1 while not loaded
//  oLoadDone      out  1            last frame loaded and checksum good
//  oError         out  1            last frame rejected
// BEHAVIOUR
//  - Accept = iByteValid & oByteReady at a rising edge; nothing else advances state.
//  - Frame: SYNC(8'hA5), CNT_HI, CNT_LO, then N=CNT*4 data bytes, then CHK. CHK = XOR of CNT_HI, CNT_LO and all data bytes.
//  - Reset (Reset==0 at edge): state IDLE, oCpuReset=1, oWriteEnable=0, oWriteAddress=0, oInstruction=0,
//    oLoadDone=0, oError=0, byte counter=0, checksum=0. oByteReady=1 the first cycle after reset.
//  - FSM: IDLE -(accept A5)-> CNT_HI -> CNT_LO -> DATA (CNT>0) or CHECK (CNT==0) -> DONE | ERROR.
//    IDLE: non-A5 bytes accepted and discarded.
//    CNT_LO: if CNT > 2**ADDR_WIDTH, go to ERROR on that edge (no writes).
//    DATA: bytes shifted into a 32-bit assembler; on the 4th byte's accept edge, oWriteEnable=1 the next
//          cycle for exactly 1 cycle with oInstruction=word[INSTR_WIDTH-1:0], oWriteAddress=word index.
//          oByteReady=0 during that write cycle (one-cycle stall per word). After word CNT-1 -> CHECK.
//    CHECK: accepted byte == running XOR -> DONE, else ERROR.
//    DONE: oLoadDone=1, oCpuReset=0 from the cycle after the CHK accept edge.
//    ERROR: oError=1, oCpuReset=1.
//    DONE/ERROR: oByteReady=1; accepting A5 restarts (-> CNT_HI, oCpuReset=1, oLoadDone=0, oError=0, address 0);
//                other bytes discarded.
//  - oWriteAddress wraps never: max index 2**ADDR_WIDTH-1 guaranteed by the CNT check.
//  - Gaps in iByteValid anywhere (incl. mid-word) are legal and change nothing.
//  - Reset mid-frame: abort to IDLE; words already written remain in memory, partial word is discarded,
//    oCpuReset=1 until a later frame completes.
//  - All outputs registered except oByteReady (decoded from state/write-cycle flag).
// STRUCTURE
//  - Shared definitions file (alongside the opcode definitions): state encodings, `LOADER_SYNC 8'hA5.
//  - One sub-module: loader_word_assembler (4-byte shift register + 2-bit byte counter, word_ready pulse).
//  - Address/word counter, XOR accumulator, FSM in program_loader.
// TESTING
//  1. Reset low 3 cycles -> oCpuReset=1, oWriteEnable=0, oLoadDone=0, oError=0; oByteReady=1 after release.
//  2. Send A5 00 01 00 A1 B2 C3 D1 -> one write: addr 0, data 28'h0A1B2C3; oLoadDone=1, oCpuReset=0.
//  3. Same frame with CHK=D0 -> write still occurs at addr 0; oError=1, oCpuReset stays 1, oLoadDone=0.
//  4. Send 12 34 A5 00 00 00 -> leading bytes ignored, no writes, oLoadDone=1; then A5 restarts: oCpuReset=1, oLoadDone=0.
//  5. Two-word frame with random iByteValid gaps -> writes at addr 0,1; oByteReady low exactly the write cycles.
//  6. Reset mid-DATA after 2 bytes -> IDLE, no write; next full frame loads from addr 0.
//     With ADDR_WIDTH=2, CNT=5 -> oError=1 on CNT_LO, zero writes.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared loader definitions: frame sync byte and FSM state encoding.
package program_loader_pkg;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_HI = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_e;

  // True when a word count cannot be addressed with addr_width bits.
  function automatic logic count_too_big(input logic [15:0] cnt, input int unsigned addr_width);
    logic [32:0] limit;
    limit = 33'd1 << addr_width;
    return ({17'd0, cnt} > limit);
  endfunction

endpackage

// File: rtl/program_loader_assembler.sv
// Shifts accepted bytes MSB-first into an instruction word; word_rdy pulses with the 4th byte.
// Only the low OUT_WIDTH bits are kept, so the dropped top bits simply shift out.
module loader_word_assembler #(
  parameter int OUT_WIDTH = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 byte_vld,
  input  logic [7:0]           byte_dat,
  output logic                 word_rdy,
  output logic [OUT_WIDTH-1:0] word_dat
);

  logic [OUT_WIDTH-9:0] shift_q, shift_d;
  logic [1:0]           cnt_q, cnt_d;

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    word_rdy = byte_vld && (cnt_q == 2'd3);
    word_dat = {shift_q, byte_dat};
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_vld) begin
      shift_d = {shift_q[OUT_WIDTH-17:0], byte_dat};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader for the instruction memory; holds the CPU in reset until a
// checksum-verified frame has been written. Stalls the stream for one cycle per word write.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 28
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [7:0]             iByte,
  input  logic                   iByteValid,
  output logic                   oByteReady,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddress,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic                   oCpuReset,
  output logic                   oLoadDone,
  output logic                   oError
);

  loader_state_e          state_q, state_d;
  logic [7:0]             cnt_hi_q, cnt_hi_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [16:0]            word_idx_q, word_idx_d;
  logic [7:0]             chk_q, chk_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   asm_vld;
  logic                   asm_clear;
  logic                   word_rdy;
  logic [INSTR_WIDTH-1:0] word_dat;
  logic [15:0]            cnt_full;

  // The only stall is the write cycle itself.
  assign oByteReady = ~we_q;
  assign accept     = iByteValid & oByteReady;
  assign asm_vld    = accept && (state_q == ST_DATA);
  assign asm_clear  = (state_q != ST_DATA);
  assign cnt_full   = {cnt_hi_q, iByte};

  loader_word_assembler #(
    .OUT_WIDTH (INSTR_WIDTH)
  ) u_asm (
    .clk      (Clock),
    .rst_n    (Reset),
    .clear    (asm_clear),
    .byte_vld (asm_vld),
    .byte_dat (iByte),
    .word_rdy (word_rdy),
    .word_dat (word_dat)
  );

  always_comb begin
    state_d    = state_q;
    cnt_hi_d   = cnt_hi_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    chk_d      = chk_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    instr_d    = instr_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;

    if (accept) begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (iByte == LOADER_SYNC) begin
            state_d    = ST_CNT_HI;
            chk_d      = '0;
            word_idx_d = '0;
            addr_d     = '0;
            cpu_rst_d  = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
          end
        end
        ST_CNT_HI: begin
          cnt_hi_d = iByte;
          chk_d    = chk_q ^ iByte;
          state_d  = ST_CNT_LO;
        end
        ST_CNT_LO: begin
          cnt_d = cnt_full;
          chk_d = chk_q ^ iByte;
          if (count_too_big(cnt_full, ADDR_WIDTH)) begin
            state_d   = ST_ERROR;
            err_d     = 1'b1;
            cpu_rst_d = 1'b1;
          end else if (cnt_full == 16'd0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          chk_d = chk_q ^ iByte;
          if (word_rdy) begin
            we_d       = 1'b1;
            addr_d     = word_idx_q[ADDR_WIDTH-1:0];
            instr_d    = word_dat;
            word_idx_d = word_idx_q + 17'd1;
            if ((word_idx_q + 17'd1) == {1'b0, cnt_q}) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (iByte == chk_q) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d   = ST_ERROR;
            err_d     = 1'b1;
            cpu_rst_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      cnt_hi_q   <= '0;
      cnt_q      <= '0;
      word_idx_q <= '0;
      chk_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      instr_q    <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_hi_q   <= cnt_hi_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      chk_q      <= chk_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oInstruction  = instr_q;
  assign oCpuReset     = cpu_rst_q;
  assign oLoadDone     = done_q;
  assign oError        = err_q;

endmodule
